// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache between the IFU fetch port and an
// AXI4-style read master; refills whole lines in order and supports fence.i.
module ysyx_23060025_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SET_NUM    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_psel,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  output logic                  in_pready,
  output logic [DATA_WIDTH-1:0] in_prdata,
  input  logic                  fence_i,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [7:0]            mem_arlen,
  output logic [2:0]            mem_arsize,
  output logic [1:0]            mem_arburst,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rlast,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
  output logic [2:0]            dbg_state_o
);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int IDX_W = $clog2(SET_NUM);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MISS_AR = 3'd2,
    REFILL  = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:2]   req_addr_q;
  logic [SET_NUM-1:0]      valid_q;
  logic [TAG_W-1:0]        tag_q  [SET_NUM];
  logic [DATA_WIDTH-1:0]   data_q [SET_NUM][LINE_WORDS];
  logic                    fence_pend_q;
  logic                    hit_q;
  logic [WRD_W-1:0]        beat_q;
  logic                    pready_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [31:0]             hit_cnt_q;
  logic [31:0]             miss_cnt_q;

  logic [IDX_W-1:0] in_idx, req_idx;
  logic [WRD_W-1:0] in_word, req_word;
  logic [TAG_W-1:0] in_tag, req_tag;
  logic             in_hit;
  logic             unused_low;

  assign in_idx   = in_paddr[OFF_W +: IDX_W];
  assign in_word  = in_paddr[2 +: WRD_W];
  assign in_tag   = in_paddr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_word = req_addr_q[2 +: WRD_W];
  assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign unused_low = ^in_paddr[1:0];

  // Tag check is done on the incoming address at acceptance so the hit
  // response can be registered and still appear during the LOOKUP cycle.
  assign in_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      valid_q      <= '0;
      fence_pend_q <= 1'b0;
      hit_q        <= 1'b0;
      beat_q       <= '0;
      pready_q     <= 1'b0;
      prdata_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      pready_q <= 1'b0;
      if (fence_i) fence_pend_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (fence_pend_q || fence_i) begin
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
          end else if (in_psel) begin
            req_addr_q <= in_paddr[ADDR_WIDTH-1:2];
            hit_q      <= in_hit;
            state_q    <= LOOKUP;
            if (in_hit) begin
              pready_q <= 1'b1;
              prdata_q <= data_q[in_idx][in_word];
            end
          end
        end
        LOOKUP: begin
          if (hit_q) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
            state_q   <= IDLE;
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
            arvalid_q  <= 1'b1;
            araddr_q   <= {req_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            state_q    <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (mem_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            data_q[req_idx][beat_q] <= mem_rdata;
            beat_q <= beat_q + 1'b1;
            if (mem_rlast) begin
              tag_q[req_idx]   <= req_tag;
              valid_q[req_idx] <= 1'b1;
              rready_q         <= 1'b0;
              pready_q         <= 1'b1;
              // The requested word may be the beat arriving right now.
              prdata_q <= (beat_q == req_word) ? mem_rdata : data_q[req_idx][req_word];
              state_q  <= RESP;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_pready   = pready_q;
  assign in_prdata   = prdata_q;
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_arlen   = 8'(LINE_WORDS - 1);
  assign mem_arsize  = 3'b010;
  assign mem_arburst = 2'b01;
  assign mem_rready  = rready_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed bench for the instruction cache: misses, hits, conflicts, fences,
// AXI backpressure and reset in the middle of a burst.
module tb_ysyx_23060025_icache;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;

  logic        clock, reset;
  logic        in_psel;
  logic [31:0] in_paddr;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        fence_i;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic        mem_rvalid, mem_rready, mem_rlast;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int misc    = 0;

  ysyx_23060025_icache dut (
    .clock(clock), .reset(reset),
    .in_psel(in_psel), .in_paddr(in_paddr), .in_pready(in_pready), .in_prdata(in_prdata),
    .fence_i(fence_i),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state_o(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request and hold psel until the cache accepts it.
  task automatic issue(input logic [31:0] a);
    int n;
    n = 0;
    in_psel  = 1'b1;
    in_paddr = a;
    do begin
      tick();
      n++;
    end while (dbg_state !== S_LOOKUP && n < 4);
    in_psel = 1'b0;
    if (dbg_state !== S_LOOKUP) begin
      vectors++; misc++;
      $display("FAIL accept_timeout: state %0d want %0d for addr %h", dbg_state, S_LOOKUP, a);
    end
  endtask

  // Wait for AR, stall arready for 'delay' cycles, then handshake.
  task automatic serve_ar(input int delay, output logic [31:0] addr, output logic stable);
    int n;
    n = 0;
    stable = 1'b1;
    addr = '0;
    while (mem_arvalid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (mem_arvalid !== 1'b1) begin
      vectors++; misc++;
      $display("FAIL ar_timeout: arvalid %b want 1", mem_arvalid);
      return;
    end
    addr = mem_araddr;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (mem_arvalid !== 1'b1 || mem_araddr !== addr) stable = 1'b0;
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
  endtask

  // Four beats base, base+step, ...; 'gap' idle cycles before each beat.
  task automatic serve_r(input logic [31:0] base, input logic [31:0] step, input int gap,
                         input int fence_beat, output logic rr_ok);
    rr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rvalid = 1'b0;
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = base + step * i;
      mem_rlast  = (i == 3);
      fence_i    = (i == fence_beat);
      if (mem_rready !== 1'b1) rr_ok = 1'b0;
      tick();
      fence_i = 1'b0;
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({in_pready, in_prdata, mem_arvalid, mem_rready, mem_araddr, hit_cnt, miss_cnt, dbg_state} !== '0) begin
      misc++;
      $display("FAIL reset_outputs: pready %b prdata %h arvalid %b rready %b araddr %h hit %0d miss %0d state %0d want all 0",
               in_pready, in_prdata, mem_arvalid, mem_rready, mem_araddr, hit_cnt, miss_cnt, dbg_state);
    end
    vectors++;
    if ({mem_arlen, mem_arsize, mem_arburst} !== {8'd3, 3'b010, 2'b01}) begin
      misc++;
      $display("FAIL ar_consts: len %0d size %0d burst %0d want 3 2 1", mem_arlen, mem_arsize, mem_arburst);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    logic [31:0] a;
    logic st, rr;
    issue(32'h8000_0004);
    vectors++;
    if (in_pready !== 1'b0) begin misc++; $display("FAIL cold_lookup_pready: got %b want 0", in_pready); end
    serve_ar(0, a, st);
    vectors++;
    if (a !== 32'h8000_0000) begin misc++; $display("FAIL cold_araddr: got %h want 80000000", a); end
    vectors++;
    if (mem_arlen !== 8'd3) begin misc++; $display("FAIL cold_arlen: got %0d want 3", mem_arlen); end
    serve_r(32'h11, 32'h11, 0, -1, rr);
    vectors++;
    if (rr !== 1'b1) begin misc++; $display("FAIL cold_rready: got %b want 1", rr); end
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h22) begin
      misc++; $display("FAIL cold_resp: pready %b data %h want 1 00000022", in_pready, in_prdata);
    end
    vectors++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      misc++; $display("FAIL cold_counts: miss %0d hit %0d want 1 0", miss_cnt, hit_cnt);
    end
    tick();
    vectors++;
    if (in_pready !== 1'b0 || in_prdata !== 32'h22 || dbg_state !== S_IDLE) begin
      misc++; $display("FAIL cold_after: pready %b data %h state %0d want 0 00000022 0", in_pready, in_prdata, dbg_state);
    end
  endtask

  task automatic test_hit();
    issue(32'h8000_000C);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h44) begin
      misc++; $display("FAIL hit_resp: pready %b data %h want 1 00000044", in_pready, in_prdata);
    end
    tick();
    vectors++;
    if (hit_cnt !== 32'd1 || mem_arvalid !== 1'b0 || in_pready !== 1'b0) begin
      misc++; $display("FAIL hit_after: hit %0d arvalid %b pready %b want 1 0 0", hit_cnt, mem_arvalid, in_pready);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] a;
    logic st, rr;
    issue(32'h8000_010C);
    vectors++;
    if (in_pready !== 1'b0) begin misc++; $display("FAIL conf_lookup_pready: got %b want 0", in_pready); end
    serve_ar(0, a, st);
    vectors++;
    if (a !== 32'h8000_0100) begin misc++; $display("FAIL conf_araddr: got %h want 80000100", a); end
    serve_r(32'hA0, 32'h1, 0, -1, rr);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'hA3) begin
      misc++; $display("FAIL conf_resp: pready %b data %h want 1 000000a3", in_pready, in_prdata);
    end
    tick();
    issue(32'h8000_0000);
    vectors++;
    if (in_pready !== 1'b0) begin misc++; $display("FAIL conf_remiss_pready: got %b want 0", in_pready); end
    serve_ar(0, a, st);
    vectors++;
    if (a !== 32'h8000_0000) begin misc++; $display("FAIL conf_remiss_araddr: got %h want 80000000", a); end
    serve_r(32'h11, 32'h11, 0, -1, rr);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h11 || miss_cnt !== 32'd3) begin
      misc++; $display("FAIL conf_remiss_resp: pready %b data %h miss %0d want 1 00000011 3", in_pready, in_prdata, miss_cnt);
    end
    tick();
  endtask

  task automatic test_fence_idle();
    logic [31:0] a;
    logic st, rr;
    fence_i  = 1'b1;
    in_psel  = 1'b1;
    in_paddr = 32'h8000_0008;
    tick();
    fence_i = 1'b0;
    vectors++;
    if (dbg_state !== S_IDLE) begin misc++; $display("FAIL fence_wins: state %0d want 0", dbg_state); end
    tick();
    in_psel = 1'b0;
    vectors++;
    if (dbg_state !== S_LOOKUP || in_pready !== 1'b0) begin
      misc++; $display("FAIL fence_miss: state %0d pready %b want 1 0", dbg_state, in_pready);
    end
    serve_ar(0, a, st);
    vectors++;
    if (a !== 32'h8000_0000) begin misc++; $display("FAIL fence_araddr: got %h want 80000000", a); end
    serve_r(32'h51, 32'h1, 0, -1, rr);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h53 || miss_cnt !== 32'd4) begin
      misc++; $display("FAIL fence_resp: pready %b data %h miss %0d want 1 00000053 4", in_pready, in_prdata, miss_cnt);
    end
    tick();
  endtask

  task automatic test_fence_refill();
    logic [31:0] a;
    logic st, rr;
    issue(32'h8000_0204);
    serve_ar(0, a, st);
    serve_r(32'h61, 32'h1, 0, 1, rr);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h62 || miss_cnt !== 32'd5) begin
      misc++; $display("FAIL fmid_resp: pready %b data %h miss %0d want 1 00000062 5", in_pready, in_prdata, miss_cnt);
    end
    tick();
    issue(32'h8000_0204);
    vectors++;
    if (in_pready !== 1'b0) begin misc++; $display("FAIL fmid_remiss: pready %b want 0", in_pready); end
    serve_ar(0, a, st);
    vectors++;
    if (a !== 32'h8000_0200) begin misc++; $display("FAIL fmid_araddr: got %h want 80000200", a); end
    serve_r(32'h71, 32'h1, 0, -1, rr);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h72 || miss_cnt !== 32'd6) begin
      misc++; $display("FAIL fmid_refill: pready %b data %h miss %0d want 1 00000072 6", in_pready, in_prdata, miss_cnt);
    end
    tick();
    issue(32'h8000_0204);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h72) begin
      misc++; $display("FAIL fmid_hit: pready %b data %h want 1 00000072", in_pready, in_prdata);
    end
    tick();
    vectors++;
    if (hit_cnt !== 32'd2) begin misc++; $display("FAIL fmid_hitcnt: got %0d want 2", hit_cnt); end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] a;
    logic st, rr;
    issue(32'h8000_0318);
    serve_ar(3, a, st);
    vectors++;
    if (a !== 32'h8000_0310 || st !== 1'b1) begin
      misc++; $display("FAIL bp_ar: addr %h stable %b want 80000310 1", a, st);
    end
    serve_r(32'h81, 32'h1, 2, -1, rr);
    vectors++;
    if (rr !== 1'b1) begin misc++; $display("FAIL bp_rready: got %b want 1", rr); end
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'h83 || miss_cnt !== 32'd7) begin
      misc++; $display("FAIL bp_resp: pready %b data %h miss %0d want 1 00000083 7", in_pready, in_prdata, miss_cnt);
    end
    tick();
    issue(32'h8000_0410);
    serve_ar(0, a, st);
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hB0 + i;
      tick();
    end
    mem_rvalid = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if ({in_pready, in_prdata, mem_arvalid, mem_rready, mem_araddr, hit_cnt, miss_cnt, dbg_state} !== '0) begin
      misc++;
      $display("FAIL midburst_reset: pready %b prdata %h arvalid %b rready %b araddr %h hit %0d miss %0d state %0d want all 0",
               in_pready, in_prdata, mem_arvalid, mem_rready, mem_araddr, hit_cnt, miss_cnt, dbg_state);
    end
    reset = 1'b0;
    issue(32'h8000_0318);
    vectors++;
    if (in_pready !== 1'b0) begin misc++; $display("FAIL post_reset_miss: pready %b want 0", in_pready); end
    serve_ar(0, a, st);
    vectors++;
    if (a !== 32'h8000_0310) begin misc++; $display("FAIL post_reset_araddr: got %h want 80000310", a); end
    serve_r(32'hC1, 32'h1, 0, -1, rr);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'hC3 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      misc++; $display("FAIL post_reset_resp: pready %b data %h miss %0d hit %0d want 1 000000c3 1 0",
                       in_pready, in_prdata, miss_cnt, hit_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(32'h8000_0310);
    vectors++;
    if (in_pready !== 1'b1 || in_prdata !== 32'hC1) begin
      misc++; $display("FAIL b2b_first: pready %b data %h want 1 000000c1", in_pready, in_prdata);
    end
    in_psel  = 1'b1;
    in_paddr = 32'h8000_031C;
    tick();
    vectors++;
    if (dbg_state !== S_IDLE || in_pready !== 1'b0) begin
      misc++; $display("FAIL b2b_no_accept_in_lookup: state %0d pready %b want 0 0", dbg_state, in_pready);
    end
    tick();
    in_psel = 1'b0;
    vectors++;
    if (dbg_state !== S_LOOKUP || in_pready !== 1'b1 || in_prdata !== 32'hC4) begin
      misc++; $display("FAIL b2b_second: state %0d pready %b data %h want 1 1 000000c4", dbg_state, in_pready, in_prdata);
    end
    tick();
    vectors++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      misc++; $display("FAIL b2b_counts: hit %0d miss %0d want 2 1", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; in_psel = 1'b0; in_paddr = '0; fence_i = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_fence_idle();
    test_fence_refill();
    test_backpressure_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule

// File: doc/ysyx_23060025_icache.md
Name: ysyx_23060025_icache

Overview:
Direct-mapped, read-only instruction cache that responds to the IFU fetch-request interface (paddr/psel in, pready/prdata out). On a hit it returns the instruction word one cycle after the request is accepted. On a miss it refills the whole line from memory over an AXI4-style read burst, then returns the word. It also services fence.i by invalidating all lines. It sits between the IFU stage and the memory/crossbar master port.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, instruction/beat width (only 32 supported)
LINE_WORDS, 4, words per line (power of 2, 2..16)
SET_NUM, 16, number of lines (power of 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
in_psel  in  1  fetch request valid
in_paddr  in  ADDR_WIDTH  fetch address; bits [1:0] ignored
in_pready  out  1  one-cycle pulse: in_prdata valid
in_prdata  out  32  instruction word
fence_i  in  1  invalidate all lines (one-cycle pulse)
mem_arvalid  out  1  AR valid
mem_arready  in  1  AR ready
mem_araddr  out  ADDR_WIDTH  line-aligned burst address
mem_arlen  out  8  constant LINE_WORDS-1
mem_arsize  out  3  constant 3'b010
mem_arburst  out  2  constant 2'b01 (INCR)
mem_rvalid  in  1  R valid
mem_rready  out  1  R ready
mem_rdata  in  32  R data
mem_rlast  in  1  last beat
hit_cnt  out  32  hits since reset, wraps
miss_cnt  out  32  misses since reset, wraps

Behaviour:
- Address split: offset = log2(LINE_WORDS*4) LSBs; index = next log2(SET_NUM) bits; tag = remaining bits.
- Storage: per line a valid bit, a tag and LINE_WORDS data words, all flops (combinational read).
- Reset: state IDLE; all valid bits 0; pending-fence 0; in_pready, in_prdata, mem_arvalid, mem_rready, mem_araddr, hit_cnt and miss_cnt all 0.
- States: IDLE, LOOKUP, MISS_AR, REFILL, RESP.
- IDLE: if pending-fence or fence_i is set, clear all valid bits and pending-fence, and accept no request that cycle. Else if in_psel=1, latch in_paddr into req_addr and go to LOOKUP.
- LOOKUP: hit = valid[idx] & tag match. On a hit: in_pready=1, in_prdata=data[idx][word], hit_cnt+1, go to IDLE. On a miss: miss_cnt+1, go to MISS_AR.
- Hit latency is 1 cycle after acceptance. Throughput is one request per 2 cycles. No request is accepted in LOOKUP.
- MISS_AR: mem_arvalid=1 with mem_araddr = req_addr with the offset bits zeroed. Hold both stable until mem_arready=1, then go to REFILL.
- REFILL: mem_rready=1.
  - Each beat with mem_rvalid=1 writes data[idx][beat_cnt] and increments beat_cnt (log2(LINE_WORDS) bits, cleared on entry).
  - Gaps in rvalid stall the refill with no effect.
  - On the beat with mem_rlast=1: write tag[idx], set valid[idx]=1, go to RESP.
  - The line is installed in order; no critical-word-first.
- RESP: in_pready=1 with in_prdata = the requested word from the newly filled line; go to IDLE.
- in_pready is high only in the LOOKUP-hit and RESP cycles. in_prdata holds its last value otherwise.
- Requester contract: hold in_paddr stable from acceptance to in_pready. The cache uses the latched req_addr regardless.
- fence_i outside IDLE sets pending-fence. The current refill completes and the line is installed, and data is still returned. The invalidate then takes effect in the next IDLE cycle, before any new acceptance.
- fence_i coincident with in_psel in IDLE: the fence wins and the request is not accepted. The requester keeps psel asserted and is accepted the following cycle.
- Replacement is the indexed line (direct-mapped). A conflicting refill overwrites its tag and data.
- Reset mid-operation (including mid-burst): immediate return to reset state. Memory shares the reset, so an abandoned burst is legal.
- Counters wrap modulo 2^32.

Test Plan:
1. Cold miss: reset, then request 0x8000_0004. Expect AR with araddr=0x8000_0000 and arlen=3. Feed beats 0x11, 0x22, 0x33, 0x44 (rlast on the 4th). Expect in_pready one cycle after rlast with in_prdata=0x22, and miss_cnt=1.
2. Hit: next request 0x8000_000C. Expect in_pready the cycle after acceptance with data 0x44, no AR issued, and hit_cnt=1.
3. Conflict: request 0x8000_0100 (index 0). Expect a miss and refill with 0xA0..0xA3. Then 0x8000_0000 misses again, and miss_cnt=3.
4. Fence in IDLE: pulse fence_i, then request the just-filled address. Expect a miss and a new AR.
5. Fence mid-refill: pulse fence_i during beat 2. Expect the refill to complete and the correct word to be returned. The same address then misses next time.
6. Backpressure and reset: arready delayed 3 cycles with rvalid gaps. Expect araddr to stay stable and the data to be correct. Then assert reset mid-burst: all outputs go to 0, and the next request to the same line misses.
